// File: rtl/ctrl_pkg.sv
// Shared encodings and control-bundle types for the pipelined RV64I control path.
package ctrl_pkg;

    // Major opcodes recognised by the decoder
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_W     = 7'b0111011;
    localparam logic [6:0] OP_IMM_W = 7'b0011011;

    // Writeback source select
    localparam logic [1:0] MTR_ALU  = 2'b00;
    localparam logic [1:0] MTR_IMM  = 2'b01;
    localparam logic [1:0] MTR_PC4  = 2'b10;
    localparam logic [1:0] MTR_LOAD = 2'b11;

    typedef struct packed {
        logic       alu_src_b;
        logic [3:0] alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic branch;
        logic b_type;
        logic write;
        logic read;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] mem_to_reg;
    } wb_ctrl_t;

    localparam ex_ctrl_t  EX_BUBBLE  = '{alu_src_b: 1'b0, alu_op: 4'b0000};
    localparam mem_ctrl_t MEM_BUBBLE = '{branch: 1'b0, b_type: 1'b0, write: 1'b0, read: 1'b0};
    localparam wb_ctrl_t  WB_BUBBLE  = '{reg_write: 1'b0, mem_to_reg: 2'b00};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder: control bundles, rd, rs-use flags and illegal.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit RV64W_EN = 1'b1
) (
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    output ex_ctrl_t    ex_ctrl,
    output mem_ctrl_t   mem_ctrl,
    output wb_ctrl_t    wb_ctrl,
    output logic [4:0]  rd,
    output logic        rs1_used,
    output logic        rs2_used,
    output logic        valid,
    output logic        illegal
);

    logic [6:0] opcode_s;
    logic [2:0] f3_s;
    logic       f7b5_s;
    logic [4:0] rd_field_s;
    logic       known_s;
    logic       rd_keep_s;
    logic       rs1_s;
    logic       rs2_s;
    logic       reg_write_s;
    ex_ctrl_t   raw_ex_s;
    mem_ctrl_t  raw_mem_s;
    logic [1:0] raw_mtr_s;
    logic       unused_s;

    assign opcode_s   = id_inst[6:0];
    assign f3_s       = id_inst[14:12];
    assign f7b5_s     = id_inst[30];
    assign rd_field_s = id_inst[11:7];
    // Register and remaining immediate bits are consumed by the hazard logic in the top
    assign unused_s   = ^{id_inst[31], id_inst[29:15]};

    // Opcode classification into raw (ungated) control fields
    always_comb begin
        known_s     = 1'b1;
        rd_keep_s   = 1'b1;
        rs1_s       = 1'b1;
        rs2_s       = 1'b0;
        reg_write_s = 1'b0;
        raw_ex_s    = EX_BUBBLE;
        raw_mem_s   = MEM_BUBBLE;
        raw_mtr_s   = MTR_ALU;
        case (opcode_s)
            OP_IMM: begin
                raw_ex_s    = '{alu_src_b: 1'b1, alu_op: {1'b0, f3_s}};
                reg_write_s = 1'b1;
            end
            OP: begin
                raw_ex_s    = '{alu_src_b: 1'b0, alu_op: {f7b5_s, f3_s}};
                reg_write_s = 1'b1;
                rs2_s       = 1'b1;
            end
            LOAD: begin
                raw_ex_s.alu_src_b = 1'b1;
                raw_mem_s.read     = 1'b1;
                raw_mtr_s          = MTR_LOAD;
                reg_write_s        = 1'b1;
            end
            STORE: begin
                raw_ex_s.alu_src_b = 1'b1;
                raw_mem_s.write    = 1'b1;
                rs2_s              = 1'b1;
                rd_keep_s          = 1'b0;
            end
            BRANCH: begin
                raw_ex_s.alu_op  = 4'b1000;
                raw_mem_s.branch = 1'b1;
                raw_mem_s.b_type = (f3_s == 3'b000);
                rs2_s            = 1'b1;
                rd_keep_s        = 1'b0;
            end
            LUI: begin
                raw_ex_s.alu_src_b = 1'b1;
                raw_mtr_s          = MTR_IMM;
                reg_write_s        = 1'b1;
                rs1_s              = 1'b0;
            end
            AUIPC: begin
                raw_ex_s.alu_src_b = 1'b1;
                reg_write_s        = 1'b1;
                rs1_s              = 1'b0;
            end
            JAL: begin
                raw_mtr_s   = MTR_PC4;
                reg_write_s = 1'b1;
                rs1_s       = 1'b0;
            end
            JALR: begin
                raw_ex_s.alu_src_b = 1'b1;
                raw_mtr_s          = MTR_PC4;
                reg_write_s        = 1'b1;
            end
            SYSTEM: begin
                reg_write_s = 1'b1;
            end
            OP_W: begin
                if (RV64W_EN) begin
                    raw_ex_s    = '{alu_src_b: 1'b0, alu_op: {1'b1, f3_s}};
                    reg_write_s = 1'b1;
                    rs2_s       = 1'b1;
                end else begin
                    known_s = 1'b0;
                end
            end
            OP_IMM_W: begin
                if (RV64W_EN) begin
                    raw_ex_s    = '{alu_src_b: 1'b1, alu_op: {1'b1, f3_s}};
                    reg_write_s = 1'b1;
                end else begin
                    known_s = 1'b0;
                end
            end
            default: begin
                known_s = 1'b0;
            end
        endcase
    end

    assign valid    = id_valid & known_s;
    assign illegal  = id_valid & ~known_s;
    assign rd       = (valid && rd_keep_s) ? rd_field_s : 5'd0;
    assign rs1_used = valid & rs1_s;
    assign rs2_used = valid & rs2_s;
    assign ex_ctrl  = valid ? raw_ex_s  : EX_BUBBLE;
    assign mem_ctrl = valid ? raw_mem_s : MEM_BUBBLE;
    // A write to x0 is suppressed here so downstream never sees it
    assign wb_ctrl  = valid ? '{reg_write: reg_write_s & (rd != 5'd0), mem_to_reg: raw_mtr_s}
                            : WB_BUBBLE;

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control path: ID decode, ID/EX, EX/MEM, MEM/WB registers and load-use stall.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_W    = 4,
    parameter bit          RV64W_EN    = 1'b1,
    parameter bit          LOAD_USE_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [31:0]         id_inst,
    input  logic                flush,
    output logic                stall_id,
    output logic                illegal,
    output logic                ex_valid,
    output logic                ex_alu_src_b,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [4:0]          ex_rd,
    output logic                mem_valid,
    output logic                mem_branch,
    output logic                mem_b_type,
    output logic                mem_write,
    output logic                mem_read,
    output logic [4:0]          mem_rd,
    output logic                wb_valid,
    output logic                wb_reg_write,
    output logic [1:0]          wb_mem_to_reg,
    output logic [4:0]          wb_rd
);

    ex_ctrl_t   dec_ex_s;
    mem_ctrl_t  dec_mem_s;
    wb_ctrl_t   dec_wb_s;
    logic [4:0] dec_rd_s;
    logic       dec_rs1_s;
    logic       dec_rs2_s;
    logic       dec_valid_s;
    logic       hit_s;
    logic       stall_s;

    logic       ex_valid_r;
    ex_ctrl_t   ex_ctrl_r;
    mem_ctrl_t  ex_mem_r;
    wb_ctrl_t   ex_wb_r;
    logic [4:0] ex_rd_r;
    logic       mem_valid_r;
    mem_ctrl_t  mem_ctrl_r;
    wb_ctrl_t   mem_wb_r;
    logic [4:0] mem_rd_r;
    logic       wb_valid_r;
    wb_ctrl_t   wb_ctrl_r;
    logic [4:0] wb_rd_r;

    ctrl_decode #(.RV64W_EN(RV64W_EN)) u_decode (
        .id_valid (id_valid),
        .id_inst  (id_inst),
        .ex_ctrl  (dec_ex_s),
        .mem_ctrl (dec_mem_s),
        .wb_ctrl  (dec_wb_s),
        .rd       (dec_rd_s),
        .rs1_used (dec_rs1_s),
        .rs2_used (dec_rs2_s),
        .valid    (dec_valid_s),
        .illegal  (illegal)
    );

    // Load-use detection against the load sitting in EX; flush masks it since ID is discarded
    always_comb begin
        hit_s = (dec_rs1_s && (id_inst[19:15] == ex_rd_r)) ||
                (dec_rs2_s && (id_inst[24:20] == ex_rd_r));
        if (LOAD_USE_EN && !flush && ex_valid_r && ex_mem_r.read &&
            (ex_rd_r != 5'd0) && id_valid && hit_s) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // ID/EX register: takes a bubble on flush or stall, else the decoded instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= EX_BUBBLE;
            ex_mem_r   <= MEM_BUBBLE;
            ex_wb_r    <= WB_BUBBLE;
            ex_rd_r    <= 5'd0;
        end else if (flush || stall_s) begin
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= EX_BUBBLE;
            ex_mem_r   <= MEM_BUBBLE;
            ex_wb_r    <= WB_BUBBLE;
            ex_rd_r    <= 5'd0;
        end else begin
            ex_valid_r <= dec_valid_s;
            ex_ctrl_r  <= dec_ex_s;
            ex_mem_r   <= dec_mem_s;
            ex_wb_r    <= dec_wb_s;
            ex_rd_r    <= dec_rd_s;
        end
    end

    // EX/MEM register: always advances so the branch-resolving instruction completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_r <= 1'b0;
            mem_ctrl_r  <= MEM_BUBBLE;
            mem_wb_r    <= WB_BUBBLE;
            mem_rd_r    <= 5'd0;
        end else begin
            mem_valid_r <= ex_valid_r;
            mem_ctrl_r  <= ex_mem_r;
            mem_wb_r    <= ex_wb_r;
            mem_rd_r    <= ex_rd_r;
        end
    end

    // MEM/WB register: always advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_r <= 1'b0;
            wb_ctrl_r  <= WB_BUBBLE;
            wb_rd_r    <= 5'd0;
        end else begin
            wb_valid_r <= mem_valid_r;
            wb_ctrl_r  <= mem_wb_r;
            wb_rd_r    <= mem_rd_r;
        end
    end

    assign stall_id      = stall_s;
    assign ex_valid      = ex_valid_r;
    assign ex_alu_src_b  = ex_ctrl_r.alu_src_b;
    assign ex_alu_op     = ALU_OP_W'(ex_ctrl_r.alu_op);
    assign ex_rd         = ex_rd_r;
    assign mem_valid     = mem_valid_r;
    assign mem_branch    = mem_ctrl_r.branch;
    assign mem_b_type    = mem_ctrl_r.b_type;
    assign mem_write     = mem_ctrl_r.write;
    assign mem_read      = mem_ctrl_r.read;
    assign mem_rd        = mem_rd_r;
    assign wb_valid      = wb_valid_r;
    // Bubbles carry reg_write=0, so this is already qualified by wb_valid
    assign wb_reg_write  = wb_ctrl_r.reg_write;
    assign wb_mem_to_reg = wb_ctrl_r.mem_to_reg;
    assign wb_rd         = wb_rd_r;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomised self-checking bench for ctrl_pipe against an instruction-level model.
module tb_ctrl_pipe;

    typedef struct packed {
        bit       v;
        bit       srcb;
        bit [3:0] op;
        bit [4:0] rd;
        bit       br;
        bit       bt;
        bit       mw;
        bit       mr;
        bit       rw;
        bit [1:0] mtr;
    } rec_t;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        flush;

    logic        stall_id, illegal, ex_valid, ex_alu_src_b;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        mem_valid, mem_branch, mem_b_type, mem_write, mem_read;
    logic        wb_valid, wb_reg_write;
    logic [1:0]  wb_mem_to_reg;

    logic        stall2, illegal2, ex_valid2, ex_alu_src_b2;
    logic [5:0]  ex_alu_op2;
    logic [4:0]  ex_rd2, mem_rd2, wb_rd2;
    logic        mem_valid2, mem_branch2, mem_b_type2, mem_write2, mem_read2;
    logic        wb_valid2, wb_reg_write2;
    logic [1:0]  wb_mem_to_reg2;

    int n_tests = 0;
    int n_fail  = 0;

    rec_t ex_m, mem_m, wb_m;
    bit   m_stall, m_ill, m_ill2;

    ctrl_pipe dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
        .stall_id(stall_id), .illegal(illegal), .ex_valid(ex_valid),
        .ex_alu_src_b(ex_alu_src_b), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_branch(mem_branch), .mem_b_type(mem_b_type),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd)
    );

    ctrl_pipe #(.ALU_OP_W(6), .RV64W_EN(1'b0), .LOAD_USE_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
        .stall_id(stall2), .illegal(illegal2), .ex_valid(ex_valid2),
        .ex_alu_src_b(ex_alu_src_b2), .ex_alu_op(ex_alu_op2), .ex_rd(ex_rd2),
        .mem_valid(mem_valid2), .mem_branch(mem_branch2), .mem_b_type(mem_b_type2),
        .mem_write(mem_write2), .mem_read(mem_read2), .mem_rd(mem_rd2),
        .wb_valid(wb_valid2), .wb_reg_write(wb_reg_write2),
        .wb_mem_to_reg(wb_mem_to_reg2), .wb_rd(wb_rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level meaning of one ID-stage instruction
    function automatic rec_t mdl(input bit v, input bit [31:0] i, input bit wen,
                                 output bit ill, output bit u1, output bit u2);
        rec_t     r;
        bit       legal;
        bit [6:0] o;
        bit [2:0] f3;
        r  = '0;
        o  = i[6:0];
        f3 = i[14:12];
        legal = (o == 7'h13) || (o == 7'h33) || (o == 7'h03) || (o == 7'h23) ||
                (o == 7'h63) || (o == 7'h37) || (o == 7'h17) || (o == 7'h6F) ||
                (o == 7'h67) || (o == 7'h73) || (wen && ((o == 7'h3B) || (o == 7'h1B)));
        ill = v && !legal;
        u1  = 1'b0;
        u2  = 1'b0;
        if (!(v && legal)) return r;
        r.v  = 1'b1;
        u1   = !((o == 7'h37) || (o == 7'h17) || (o == 7'h6F));
        u2   = (o == 7'h33) || (o == 7'h23) || (o == 7'h63) || (o == 7'h3B);
        r.srcb = (o inside {7'h13, 7'h1B, 7'h03, 7'h23, 7'h37, 7'h17, 7'h67});
        if (o == 7'h13)                      r.op = {1'b0, f3};
        else if (o == 7'h33)                 r.op = {i[30], f3};
        else if (o == 7'h63)                 r.op = 4'd8;
        else if (o == 7'h3B || o == 7'h1B)   r.op = {1'b1, f3};
        else                                 r.op = 4'd0;
        r.br  = (o == 7'h63);
        r.bt  = (o == 7'h63) && (f3 == 3'd0);
        r.mw  = (o == 7'h23);
        r.mr  = (o == 7'h03);
        r.rd  = ((o == 7'h23) || (o == 7'h63)) ? 5'd0 : i[11:7];
        r.rw  = (r.rd != 5'd0) && !((o == 7'h23) || (o == 7'h63));
        r.mtr = (o == 7'h03) ? 2'd3 : ((o == 7'h6F) || (o == 7'h67)) ? 2'd2 : (o == 7'h37) ? 2'd1 : 2'd0;
        return r;
    endfunction

    task automatic compare();
        chk("stall_id",      64'(stall_id),      64'(m_stall));
        chk("illegal",       64'(illegal),       64'(m_ill));
        chk("ex_valid",      64'(ex_valid),      64'(ex_m.v));
        chk("ex_alu_src_b",  64'(ex_alu_src_b),  64'(ex_m.srcb));
        chk("ex_alu_op",     64'(ex_alu_op),     64'(ex_m.op));
        chk("ex_rd",         64'(ex_rd),         64'(ex_m.rd));
        chk("mem_valid",     64'(mem_valid),     64'(mem_m.v));
        chk("mem_branch",    64'(mem_branch),    64'(mem_m.br));
        chk("mem_b_type",    64'(mem_b_type),    64'(mem_m.bt));
        chk("mem_write",     64'(mem_write),     64'(mem_m.mw));
        chk("mem_read",      64'(mem_read),      64'(mem_m.mr));
        chk("mem_rd",        64'(mem_rd),        64'(mem_m.rd));
        chk("wb_valid",      64'(wb_valid),      64'(wb_m.v));
        chk("wb_reg_write",  64'(wb_reg_write),  64'(wb_m.rw));
        chk("wb_mem_to_reg", 64'(wb_mem_to_reg), 64'(wb_m.mtr));
        chk("wb_rd",         64'(wb_rd),         64'(wb_m.rd));
        chk("illegal_w_off", 64'(illegal2),      64'(m_ill2));
        chk("stall_lu_off",  64'(stall2),        64'd0);
        chk("alu_op_zext",   64'(ex_alu_op2[5:4]), 64'd0);
    endtask

    // One clock: drive at negedge, check before the posedge, advance model on the posedge
    task automatic cycle(input bit v, input bit [31:0] inst, input bit fl, output bit st);
        rec_t dec;
        bit   u1, u2, d1, d2;
        id_valid = v;
        id_inst  = inst;
        flush    = fl;
        #1;
        dec = mdl(v, inst, 1'b1, m_ill, u1, u2);
        void'(mdl(v, inst, 1'b0, m_ill2, d1, d2));
        m_stall = !fl && ex_m.v && ex_m.mr && (ex_m.rd != 5'd0) && v &&
                  ((u1 && inst[19:15] == ex_m.rd) || (u2 && inst[24:20] == ex_m.rd));
        compare();
        st = stall_id;
        @(posedge clk);
        wb_m  = mem_m;
        mem_m = ex_m;
        ex_m  = (fl || m_stall) ? rec_t'(0) : dec;
        @(negedge clk);
    endtask

    function automatic bit [31:0] rand_inst();
        bit [6:0]  opcs [12];
        bit [31:0] r;
        int        k;
        opcs = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73, 7'h3B, 7'h1B};
        r = $urandom;
        k = $urandom_range(0, 12);
        if (k < 12) r[6:0] = opcs[k];
        r[11:7]  = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    localparam bit [31:0] ADDI_X1 = 32'h0050_0093;
    localparam bit [31:0] ADDI_X2 = 32'h0050_0113;
    localparam bit [31:0] LW_X5   = 32'h0001_2283;
    localparam bit [31:0] ADD_X6  = 32'h0012_8333;
    localparam bit [31:0] ADDI_X7 = 32'h0050_0393;
    localparam bit [31:0] FENCE   = 32'h0000_000F;
    localparam bit [31:0] ADDW    = 32'h0031_00BB;
    localparam bit [31:0] ADD_X0  = 32'h0020_8033;

    initial begin
        bit st;
        bit hold;
        bit v;
        bit fl;
        bit [31:0] inst;
        rst = 1'b1; id_valid = 1'b0; id_inst = 32'd0; flush = 1'b0;
        ex_m = '0; mem_m = '0; wb_m = '0;
        m_stall = 1'b0; m_ill = 1'b0; m_ill2 = 1'b0;
        @(negedge clk); @(negedge clk);
        compare();
        rst = 1'b0;

        // addi x1,x0,5 through the pipe
        cycle(1'b1, ADDI_X1, 1'b0, st);
        chk("addi_ex_op",   64'(ex_alu_op),    64'd0);
        chk("addi_ex_srcb", 64'(ex_alu_src_b), 64'd1);
        cycle(1'b0, 32'd0, 1'b0, st);
        chk("addi_mem_v",   64'(mem_valid),    64'd1);
        cycle(1'b0, 32'd0, 1'b0, st);
        chk("addi_wb_rw",   64'(wb_reg_write), 64'd1);
        chk("addi_wb_mtr",  64'(wb_mem_to_reg), 64'd0);
        chk("addi_wb_rd",   64'(wb_rd),        64'd1);

        // load-use: one bubble, then the add enters EX
        cycle(1'b1, LW_X5, 1'b0, st);
        cycle(1'b1, ADD_X6, 1'b0, st);
        chk("lu_stall",     64'(st),           64'd1);
        chk("lu_bubble",    64'(ex_valid),     64'd0);
        cycle(1'b1, ADD_X6, 1'b0, st);
        chk("lu_once",      64'(st),           64'd0);
        chk("lu_add_ex",    64'(ex_rd),        64'd6);

        // flush beats stall
        cycle(1'b1, LW_X5, 1'b0, st);
        cycle(1'b1, ADD_X6, 1'b1, st);
        chk("fl_stall",     64'(st),           64'd0);
        chk("fl_ex_v",      64'(ex_valid),     64'd0);
        chk("fl_mem_read",  64'(mem_read),     64'd1);
        chk("fl_mem_rd",    64'(mem_rd),       64'd5);

        // unused rs2 field must not stall
        cycle(1'b1, LW_X5, 1'b0, st);
        cycle(1'b1, ADDI_X7, 1'b0, st);
        chk("rs2_nostall",  64'(st),           64'd0);

        // illegal opcode and W-op with W disabled
        id_valid = 1'b1; id_inst = FENCE; #1;
        chk("fence_ill",    64'(illegal),      64'd1);
        cycle(1'b1, FENCE, 1'b0, st);
        chk("fence_bubble", 64'(ex_valid),     64'd0);
        id_inst = ADDW; #1;
        chk("addw_ill_off", 64'(illegal2),     64'd1);
        chk("addw_ok_on",   64'(illegal),      64'd0);
        cycle(1'b1, ADDW, 1'b0, st);
        chk("addw_bub_off", 64'(ex_valid2),    64'd0);

        // add x0 never writes
        cycle(1'b1, ADD_X0, 1'b0, st);
        cycle(1'b0, 32'd0, 1'b0, st);
        cycle(1'b0, 32'd0, 1'b0, st);
        chk("x0_wb_v",      64'(wb_valid),     64'd1);
        chk("x0_wb_rw",     64'(wb_reg_write), 64'd0);

        // asynchronous reset with three live stages and a pending stall
        cycle(1'b1, ADDI_X1, 1'b0, st);
        cycle(1'b1, ADDI_X2, 1'b0, st);
        cycle(1'b1, LW_X5, 1'b0, st);
        id_valid = 1'b1; id_inst = ADD_X6; #1;
        chk("pre_rst_stall", 64'(stall_id),    64'd1);
        rst = 1'b1; #1;
        chk("rst_ex_v",     64'(ex_valid),     64'd0);
        chk("rst_mem_v",    64'(mem_valid),    64'd0);
        chk("rst_wb_v",     64'(wb_valid),     64'd0);
        chk("rst_wb_rw",    64'(wb_reg_write), 64'd0);
        chk("rst_stall",    64'(stall_id),     64'd0);
        ex_m = '0; mem_m = '0; wb_m = '0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;

        // randomised traffic; a stalled instruction is re-presented
        hold = 1'b0; inst = 32'd0; v = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                v    = ($urandom_range(0, 99) < 85);
                inst = rand_inst();
            end
            fl = ($urandom_range(0, 99) < 10);
            cycle(v, inst, fl, st);
            if (hold && st) begin
                n_tests++;
                n_fail++;
                $display("FAIL stall_len: got 2+ cycle stall, expected 1");
            end
            hold = st;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
